// File: rtl/riscv_div_unit_pkg.sv
// riscv_pkg: shared definitions for the RV32M divide unit.
//   DIV_F3 / DIVU_F3 / REM_F3 / REMU_F3 : funct3 encodings of the divide ops.
//   div_state_t                         : divider FSM states.
package riscv_pkg;

  localparam logic [2:0] DIV_F3  = 3'b100;
  localparam logic [2:0] DIVU_F3 = 3'b101;
  localparam logic [2:0] REM_F3  = 3'b110;
  localparam logic [2:0] REMU_F3 = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // DIV and REM interpret their operands as two's complement.
  function automatic logic f3_is_signed(input logic [2:0] f3);
    return (f3 == DIV_F3) || (f3 == REM_F3);
  endfunction

  // REM and REMU return the remainder instead of the quotient.
  function automatic logic f3_is_rem(input logic [2:0] f3);
    return (f3 == REM_F3) || (f3 == REMU_F3);
  endfunction

endpackage

// File: rtl/riscv_div_unit_if.sv
// riscv_div_unit_if: execute-stage <-> divider connection.
//   start, funct3, dividend, divisor, rd_in : request from the pipeline
//   div_stall                               : to the hazard unit (DivStalled)
//   result_valid, result, rd_out            : response muxed into EX/MEM
// Modports: master = pipeline side, slave = divider side.
interface riscv_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [4:0]      rd_in;
  logic            div_stall;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, dividend, divisor, rd_in,
    input  div_stall, result_valid, result, rd_out
  );

  modport slave (
    input  start, funct3, dividend, divisor, rd_in,
    output div_stall, result_valid, result, rd_out
  );
endinterface

// File: rtl/riscv_div_unit_iter_step.sv
// div_iter_step: one combinational restoring-division step.
//   prem      in  XLEN+1 : current partial remainder
//   dvd_bit   in  1      : next dividend bit shifted in (MSB first)
//   divisor   in  XLEN   : divisor magnitude
//   prem_next out XLEN+1 : updated partial remainder
//   q_bit     out 1      : quotient bit produced by this step
module div_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   prem,
  input  logic            dvd_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   prem_next,
  output logic            q_bit
);
  localparam int PW = XLEN + 1;

  // One extra bit of headroom so the shifted remainder can never wrap.
  logic [XLEN+1:0] shifted;

  assign shifted   = {prem, dvd_bit};
  assign q_bit     = (shifted >= {2'b00, divisor});
  assign prem_next = q_bit ? PW'(shifted - {2'b00, divisor}) : PW'(shifted);
endmodule

// File: rtl/riscv_div_unit.sv
// riscv_div_unit: iterative RV32M divider (DIV, DIVU, REM, REMU).
//   clk        : pipeline clock
//   rst        : synchronous active-high reset
//   bus.slave  : start/funct3/dividend/divisor/rd_in in;
//                div_stall/result_valid/result/rd_out out
// Optional feature macro: DIV_FASTPATH_EN -- divide-by-zero and signed
// overflow skip the iterations and complete one cycle after start.
module riscv_div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int STEPS = XLEN
) (
  input logic             clk,
  input logic             rst,
  riscv_div_unit_if.slave bus
);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t state_reg, state_next;

  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN:0]    prem_reg;
  logic [XLEN-1:0]  quo_reg;          // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0]  dvs_reg;
  logic             is_rem_reg, neg_q_reg, neg_r_reg, special_reg;
  logic [XLEN-1:0]  special_val_reg;
  logic [4:0]       rd_reg;
  logic [XLEN-1:0]  result_reg;
  logic [4:0]       rd_out_reg;

  // Request decode, only meaningful in the accepting cycle.
  logic            accept, op_signed, op_rem, dvd_neg, dvs_neg;
  logic            div_zero, sgn_ovf, special;
  logic [XLEN-1:0] dvd_mag, dvs_mag, special_val;

  assign accept    = (state_reg == IDLE) && bus.start;
  assign op_signed = f3_is_signed(bus.funct3);
  assign op_rem    = f3_is_rem(bus.funct3);
  assign dvd_neg   = op_signed && bus.dividend[XLEN-1];
  assign dvs_neg   = op_signed && bus.divisor[XLEN-1];
  // Negating MIN_NEG yields MIN_NEG, which is its correct unsigned magnitude.
  assign dvd_mag   = dvd_neg ? -bus.dividend : bus.dividend;
  assign dvs_mag   = dvs_neg ? -bus.divisor  : bus.divisor;
  assign div_zero  = (bus.divisor == '0);
  assign sgn_ovf   = op_signed && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
  assign special   = div_zero || sgn_ovf;

  always_comb begin
    special_val = '0;
    if (div_zero) special_val = op_rem ? bus.dividend : '1;
    else          special_val = op_rem ? '0 : MIN_NEG;
  end

  // Restoring step datapath.
  logic [XLEN:0]   step_rem;
  logic            step_q;
  logic [XLEN-1:0] quo_next, rem_mag, quo_fin, rem_fin, final_val;
  logic            last_step;

  div_iter_step #(.XLEN(XLEN)) u_step (
    .prem      (prem_reg),
    .dvd_bit   (quo_reg[XLEN-1]),
    .divisor   (dvs_reg),
    .prem_next (step_rem),
    .q_bit     (step_q)
  );

  // After the last step the remainder is below the divisor, so it fits XLEN bits.
  assign quo_next  = {quo_reg[XLEN-2:0], step_q};
  assign rem_mag   = XLEN'(step_rem);
  assign quo_fin   = neg_q_reg ? -quo_next : quo_next;
  assign rem_fin   = neg_r_reg ? -rem_mag  : rem_mag;
  assign final_val = special_reg ? special_val_reg : (is_rem_reg ? rem_fin : quo_fin);
  assign last_step = (state_reg == RUN) && (cnt_reg == '0);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
`ifdef DIV_FASTPATH_EN
          state_next = special ? DONE : RUN;
`else
          state_next = RUN;
`endif
        end
      end
      RUN:     if (cnt_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      result_reg <= '0;
      rd_out_reg <= '0;
    end else if (accept) begin
      cnt_reg         <= CNT_LOAD;
      prem_reg        <= '0;
      quo_reg         <= dvd_mag;
      dvs_reg         <= dvs_mag;
      is_rem_reg      <= op_rem;
      neg_q_reg       <= dvd_neg ^ dvs_neg;
      neg_r_reg       <= dvd_neg;
      special_reg     <= special;
      special_val_reg <= special_val;
      rd_reg          <= bus.rd_in;
`ifdef DIV_FASTPATH_EN
      if (special) begin
        result_reg <= special_val;
        rd_out_reg <= bus.rd_in;
      end
`endif
    end else if (state_reg == RUN) begin
      prem_reg <= step_rem;
      quo_reg  <= quo_next;
      if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
      if (last_step) begin
        result_reg <= final_val;
        rd_out_reg <= rd_reg;
      end
    end
  end

  // Stall drops in DONE so the held D-stage op advances as the result retires.
  assign bus.div_stall    = !rst && (accept || (state_reg == RUN));
  assign bus.result_valid = !rst && (state_reg == DONE);
  assign bus.result       = result_reg;
  assign bus.rd_out       = rd_out_reg;
endmodule
